// File: rtl/deser_pkg.sv
// Shared types and defaults for the deserializer word-alignment block.
package deser_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } align_state_e;

    localparam int unsigned            DEF_WORD_W = 10;
    localparam logic [DEF_WORD_W-1:0]  DEF_COMMA  = 10'b0011111010;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, power-of-two depth, head word combinationally visible at out_dat.
// Latency: an entry pushed at edge N is presented at the head in the cycle after edge N.
// Backpressure: push_rdy is low only when full with no pop in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    input  logic             pop_rdy,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_dat,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             do_pop;
    logic             do_push;

    // Extra pointer MSB distinguishes full from empty when the indices coincide.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop   = pop_rdy && !empty;
    assign push_rdy = !full || do_pop;
    assign do_push  = push_vld && push_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

    assign out_vld = !empty;
    assign out_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/deser_align_ctrl.sv
// Serial-to-word aligner: hunts for a comma, verifies frame spacing, then buffers data words.
// Latency: a word completed at edge N is valid at the output in the cycle after edge N.
// Backpressure: word_valid/word_ready handshake; words arriving to a full buffer are dropped and flagged.
module deser_align_ctrl
    import deser_pkg::*;
#(
    parameter int unsigned       WORD_W      = DEF_WORD_W,
    parameter logic [WORD_W-1:0] COMMA       = WORD_W'(DEF_COMMA),
    parameter int unsigned       FRAME_WORDS = 8,
    parameter int unsigned       LOCK_CNT    = 3,
    parameter int unsigned       LOSS_CNT    = 4,
    parameter int unsigned       FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              serial_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_sof,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              locked,
    output logic              overflow
);

    localparam int unsigned BIT_W  = $clog2(WORD_W);
    localparam int unsigned IDX_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(LOSS_CNT + 1);

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_WORDS - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(LOSS_CNT - 1);

    align_state_e      state_q, state_d;
    // The oldest bit of the word-wide shift register is never examined, so only
    // WORD_W-1 history bits are kept; the full register value is cand.
    logic [WORD_W-2:0] sr_q, sr_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  word_idx_q, word_idx_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic              overflow_q, overflow_d;

    logic [WORD_W-1:0] cand;
    logic              is_comma;
    logic              word_done;
    logic [IDX_W-1:0]  idx_nxt;
    logic              push_vld;
    logic              push_sof;
    logic              push_rdy;
    logic              fifo_full;
    logic [WORD_W:0]   fifo_out;

    assign cand      = {sr_q, serial_in};
    assign sr_d      = cand[WORD_W-2:0];
    assign is_comma  = (cand == COMMA) || (cand == ~COMMA);
    assign word_done = (bit_cnt_q == BIT_LAST);
    assign idx_nxt   = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        word_idx_d = word_idx_q;
        good_cnt_d = good_cnt_q;
        miss_cnt_d = miss_cnt_q;
        push_vld   = 1'b0;
        push_sof   = 1'b0;

        case (state_q)
            HUNT: begin
                if (is_comma) begin
                    state_d    = VERIFY;
                    bit_cnt_d  = '0;
                    word_idx_d = '0;
                    good_cnt_d = GOOD_W'(1);
                    miss_cnt_d = '0;
                end
            end

            VERIFY: begin
                bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
                if (word_done) begin
                    word_idx_d = idx_nxt;
                    if (idx_nxt == '0) begin
                        if (is_comma) begin
                            good_cnt_d = good_cnt_q + 1'b1;
                            if (good_cnt_q == GOOD_LAST) begin
                                state_d    = LOCKED;
                                miss_cnt_d = '0;
                            end
                        end else begin
                            state_d    = HUNT;
                            bit_cnt_d  = '0;
                            word_idx_d = '0;
                            good_cnt_d = '0;
                        end
                    end
                end
            end

            LOCKED: begin
                bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
                if (word_done) begin
                    word_idx_d = idx_nxt;
                    if (idx_nxt == '0) begin
                        if (is_comma) begin
                            miss_cnt_d = '0;
                        end else if (miss_cnt_q == MISS_LAST) begin
                            state_d    = HUNT;
                            bit_cnt_d  = '0;
                            word_idx_d = '0;
                            good_cnt_d = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                    end else if (!is_comma) begin
                        // A comma landing in a data slot is noise: dropped silently.
                        push_vld = 1'b1;
                        push_sof = (idx_nxt == IDX_W'(1));
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // Sticky until reset; a same-cycle pop frees room, so only a refused push counts.
    assign overflow_d = overflow_q | (push_vld & ~push_rdy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            word_idx_q <= '0;
            good_cnt_q <= '0;
            miss_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            word_idx_q <= word_idx_d;
            good_cnt_q <= good_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push_vld),
        .push_dat ({push_sof, cand}),
        .push_rdy (push_rdy),
        .pop_rdy  (word_ready),
        .out_vld  (word_valid),
        .out_dat  (fifo_out),
        .full     (fifo_full)
    );

    assign word_sof = fifo_out[WORD_W];
    assign word_out = fifo_out[WORD_W-1:0];
    assign locked   = (state_q == LOCKED);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_deser_align_ctrl.sv
// Randomized bench for deser_align_ctrl against a frame-position reference model.
module tb_deser_align_ctrl;

    localparam logic [9:0] C_W   = 10'b0011111010;
    localparam logic [9:0] NC_W  = ~C_W;
    localparam logic [9:0] BAD_W = 10'h155;

    logic       clk;
    logic       rst_n;
    logic       serial_in;
    logic       word_ready;
    logic [9:0] word_out;
    logic       word_sof;
    logic       word_valid;
    logic       locked;
    logic       overflow;

    int total;
    int bad;
    bit chk_en;

    // Reference model: mode 0 = searching, 1 = confirming, 2 = aligned.
    int          m_mode;
    int          m_bits;
    int          m_good;
    int          m_miss;
    int          m_pushes;
    logic [9:0]  m_hist;
    bit          m_ovf;
    logic [10:0] mq[$];
    logic [10:0] m_pops[$];

    deser_align_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .serial_in  (serial_in),
        .word_out   (word_out),
        .word_sof   (word_sof),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .locked     (locked),
        .overflow   (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_comma(input logic [9:0] w);
        return (w == C_W) || (w == NC_W);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_bits = 0;
        m_good = 0;
        m_miss = 0;
        m_hist = '0;
        m_ovf  = 1'b0;
        mq.delete();
    endtask

    task automatic model_step(input logic b, input logic rdy);
        logic [9:0]  cand;
        logic [10:0] item;
        int          slot;
        bit          push;
        cand   = {m_hist[8:0], b};
        m_hist = cand;
        push   = 1'b0;
        item   = '0;
        if (m_mode == 0) begin
            if (is_comma(cand)) begin
                m_mode = 1;
                m_bits = 0;
                m_good = 1;
                m_miss = 0;
            end
        end else begin
            m_bits++;
            if (m_bits % 10 == 0) begin
                slot = (m_bits / 10) % 8;
                if (slot == 0) begin
                    if (is_comma(cand)) begin
                        if (m_mode == 1) begin
                            m_good++;
                            if (m_good == 3) m_mode = 2;
                        end else begin
                            m_miss = 0;
                        end
                    end else if (m_mode == 1) begin
                        m_mode = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == 4) m_mode = 0;
                    end
                end else if (m_mode == 2 && !is_comma(cand)) begin
                    push = 1'b1;
                    item = {(slot == 1), cand};
                end
            end
        end
        if (rdy && mq.size() > 0) m_pops.push_back(mq.pop_front());
        if (push) begin
            m_pushes++;
            if (mq.size() < 4) mq.push_back(item);
            else m_ovf = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 32'(word_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("word_out", 32'(word_out), 32'(mq[0][9:0]));
                chk("word_sof", 32'(word_sof), 32'(mq[0][10]));
            end
            chk("locked", 32'(locked), 32'(m_mode == 2));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic step(input logic b, input logic rdy);
        @(negedge clk);
        #1;
        serial_in  = b;
        word_ready = rdy;
        @(posedge clk);
        model_step(b, rdy);
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random, 3 high on the last bit only.
    task automatic send_word(input logic [9:0] w, input int rmode);
        logic r;
        for (int i = 9; i >= 0; i--) begin
            case (rmode)
                0:       r = 1'b0;
                1:       r = 1'b1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = (i == 0);
            endcase
            step(w[i], r);
        end
    endtask

    task automatic send_frame(input logic [9:0] c, input bit rnd, input int rmode);
        send_word(c, rmode);
        for (int k = 1; k < 8; k++) begin
            send_word(rnd ? 10'($urandom) : 10'(k), rmode);
        end
    endtask

    // Runs of at most two equal bits can never form a comma or its complement.
    task automatic send_junk(input int n);
        logic b;
        logic p1;
        logic p2;
        p1 = 1'b0;
        p2 = 1'b1;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            if (b == p1 && p1 == p2) b = ~b;
            step(b, 1'b1);
            p2 = p1;
            p1 = b;
        end
    endtask

    initial begin
        int mark;
        int pmark;
        total      = 0;
        bad        = 0;
        chk_en     = 1'b0;
        m_pushes   = 0;
        rst_n      = 1'b1;
        serial_in  = 1'b0;
        word_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #11;
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_word", 32'(word_out), 32'd0);
        chk("rst_sof", 32'(word_sof), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Acquire at a random bit offset, complement comma in the second frame.
        send_junk($urandom_range(3, 25));
        send_frame(C_W, 1'b0, 1);
        send_frame(NC_W, 1'b0, 1);
        #2 chk("pre_lock", 32'(locked), 32'd0);
        send_word(C_W, 1);
        #2 chk("lock_rise", 32'(locked), 32'd1);
        mark = m_pops.size();
        for (int k = 1; k < 8; k++) send_word(10'(k), 1);
        send_word(C_W, 1);
        chk("a_pop_cnt", 32'(m_pops.size() - mark), 32'd7);
        for (int k = 0; k < 7; k++) begin
            chk("a_pop", 32'(m_pops[mark + k]), 32'({(k == 0), 10'(k + 1)}));
        end

        // Full buffer with a pop on the push edge: no drop.
        for (int k = 1; k < 5; k++) send_word(10'(k), 0);
        send_word(10'h005, 3);
        #2;
        chk("full_pop_ovf", 32'(overflow), 32'd0);
        chk("full_pop_head", 32'(word_out), 32'h002);
        send_word(10'h006, 1);
        send_word(10'h007, 1);

        // Stalled consumer for a whole frame of data.
        send_word(C_W, 1);
        for (int k = 1; k < 8; k++) send_word(10'(k), 0);
        #2;
        chk("stall_ovf", 32'(overflow), 32'd1);
        chk("stall_head", 32'(word_out), 32'h001);
        chk("stall_sof", 32'(word_sof), 32'd1);
        mark = m_pops.size();
        send_word(NC_W, 1);
        chk("drain_cnt", 32'(m_pops.size() - mark), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pop", 32'(m_pops[mark + k]), 32'({(k == 0), 10'(k + 1)}));
        end
        for (int k = 1; k < 8; k++) send_word(10'(k), 1);

        // Random data and random consumer readiness.
        for (int f = 0; f < 4; f++) send_frame((f % 2 == 0) ? C_W : NC_W, 1'b1, 2);

        // Missing commas: three tolerated, the fourth drops lock but keeps buffered words.
        send_frame(BAD_W, 1'b0, 1);
        send_frame(BAD_W, 1'b0, 1);
        send_word(BAD_W, 1);
        for (int k = 1; k < 5; k++) send_word(10'(k), 1);
        for (int k = 5; k < 8; k++) send_word(10'(k), 0);
        #2 chk("miss3_locked", 32'(locked), 32'd1);
        send_word(BAD_W, 0);
        #2;
        chk("miss4_locked", 32'(locked), 32'd0);
        chk("miss4_valid", 32'(word_valid), 32'd1);
        chk("miss4_head", 32'(word_out), 32'h004);
        for (int k = 1; k < 8; k++) send_word(10'(k), 1);

        // Corrupt second comma while confirming.
        pmark = m_pushes;
        send_frame(C_W, 1'b0, 1);
        send_word(BAD_W, 1);
        #2;
        chk("verify_locked", 32'(locked), 32'd0);
        chk("verify_valid", 32'(word_valid), 32'd0);
        chk("verify_pushes", 32'(m_pushes - pmark), 32'd0);
        for (int k = 1; k < 8; k++) send_word(10'(k), 1);
        send_frame(C_W, 1'b0, 1);
        send_frame(NC_W, 1'b0, 1);
        send_word(C_W, 1);
        #2 chk("relock", 32'(locked), 32'd1);

        // Reset mid-word with two buffered words.
        send_word(10'h001, 0);
        send_word(10'h002, 0);
        for (int i = 9; i >= 5; i--) step(1'b0, 1'b0);
        #2 chk("pre_rst_valid", 32'(word_valid), 32'd1);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(word_valid), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_word", 32'(word_out), 32'd0);
        chk("mid_rst_sof", 32'(word_sof), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        send_junk(7);
        send_frame(C_W, 1'b0, 1);
        send_frame(C_W, 1'b0, 1);
        #2 chk("post_rst_2", 32'(locked), 32'd0);
        send_word(C_W, 1);
        #2 chk("post_rst_3", 32'(locked), 32'd1);
        for (int k = 1; k < 8; k++) send_word(10'(k), 2);
        send_word(C_W, 1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deser_align_ctrl.md
DESER_ALIGN_CTRL -- requirements
Module: deser_align_ctrl

Interface
REQ-001 Parameter WORD_W, 10, serial word width in bits.
REQ-002 Parameter COMMA, 10'b0011111010, frame alignment pattern; its bitwise complement is also accepted.
REQ-003 Parameter FRAME_WORDS, 8, words per frame including the comma at word index 0.
REQ-004 Parameter LOCK_CNT, 3, consecutive correctly spaced commas needed to declare lock.
REQ-005 Parameter LOSS_CNT, 4, consecutive missing commas needed to declare loss of lock.
REQ-006 Parameter FIFO_DEPTH, 4, output buffer depth in words (power of two).
REQ-007 clk  input  1  single clock; all logic updates on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 serial_in  input  1  serial bit stream, MSB first, one bit per clk.
REQ-010 word_out  output  WORD_W  head-of-FIFO data word.
REQ-011 word_sof  output  1  head word is the first data word of its frame.
REQ-012 word_valid  output  1  FIFO not empty.
REQ-013 word_ready  input  1  consumer accepts; a pop occurs when word_valid && word_ready.
REQ-014 locked  output  1  high in state LOCKED only.
REQ-015 overflow  output  1  sticky flag: a data word was dropped because the FIFO was full.

Function
REQ-016 The shift register SHALL update every cycle as sr <= {sr[WORD_W-2:0], serial_in}; the candidate word is cand = {sr[WORD_W-2:0], serial_in}.
REQ-017 The FSM SHALL have states HUNT, VERIFY and LOCKED.
REQ-018 HUNT: when cand equals COMMA or ~COMMA, the block SHALL clear bit_cnt and word_idx, set good_cnt=1 and enter VERIFY; otherwise it remains in HUNT.
REQ-019 VERIFY/LOCKED: bit_cnt SHALL count 0..WORD_W-1 and wrap; a word is captured on the edge where bit_cnt==WORD_W-1, and word_idx then increments modulo FRAME_WORDS.
REQ-020 A word captured with new word_idx==0 is a comma slot: a comma match is "good", anything else is "miss".
REQ-021 VERIFY: a good slot increments good_cnt and enters LOCKED when it reaches LOCK_CNT; a miss returns to HUNT; no data words are pushed in VERIFY.
REQ-022 LOCKED: a good slot clears miss_cnt; a miss increments miss_cnt and enters HUNT when it reaches LOSS_CNT; otherwise bit/word phase is unchanged.
REQ-023 LOCKED: a word at word_idx!=0 that is not a comma SHALL be pushed with sof=1 if word_idx==1, else sof=0; a comma at a data slot is dropped with no state change.
REQ-024 A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle; otherwise the word is dropped and overflow is set.
REQ-025 Latency: a word whose last bit is sampled at edge N SHALL appear with word_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-026 word_out/word_sof SHALL hold stable while word_valid && !word_ready.
REQ-027 Leaving LOCKED SHALL NOT flush the FIFO; buffered words remain drainable.
REQ-028 Pop on an empty FIFO is ignored; simultaneous push and pop on a non-empty, non-full FIFO leaves occupancy unchanged.

Reset
REQ-029 While rst_n=0: state=HUNT, sr=0, bit_cnt=word_idx=good_cnt=miss_cnt=0, FIFO empty, word_out=0, word_sof=0, word_valid=0, locked=0, overflow=0.
REQ-030 Reset mid-frame or mid-drain SHALL discard all buffered words and alignment immediately; overflow clears only on reset.

Structure
REQ-031 Package deser_pkg SHALL hold the state enum (HUNT, VERIFY, LOCKED), the default COMMA constant and the WORD_W default.
REQ-032 The output buffer SHALL be a sub-module sync_fifo (width WORD_W+1, depth FIFO_DEPTH, full/empty flags); alignment FSM and counters stay in deser_align_ctrl.

Verification
REQ-033 Stream 3 frames (comma + 7 words 10'h001..10'h007) at random bit offset -> locked rises on the 3rd comma; frame 4 data emerges in order 001..007, with sof only on 001.
REQ-034 Locked link, drop the comma in 3 consecutive frames -> stays locked; drop the 4th -> locked=0 on that edge and state returns to HUNT.
REQ-035 In VERIFY, corrupt the 2nd comma -> back to HUNT, no words pushed, locked never asserts.
REQ-036 word_ready=0 for a full frame -> 4 words buffered, next 3 dropped, overflow=1; then word_ready=1 drains 001..004 with no duplication.
REQ-037 FIFO full with word_ready=1 at the push edge -> word accepted, overflow remains 0.
REQ-038 Assert rst_n=0 mid-word while locked with 2 words buffered -> all outputs 0 immediately; after release, lock requires 3 fresh commas.
